// File: rtl/sd_card_cmd_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sd_card_cmd_responder
// Purpose  : Card-side SD CMD line engine. It receives 48-bit host commands
//            and answers them with R1 responses.
// Options  : SD_RESP_CRC_CHECK_EN - drop commands whose CRC7 does not match
// Revision : 1.0 - initial release
// ============================================================================
module sd_card_cmd_responder #(
    parameter int         NCR     = 2,
    parameter logic [5:0] NO_RESP = 6'd0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        cmd_in,
    input  logic [31:0] card_status,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_error,
    output logic        busy
);

    localparam logic [2:0] c_s_idle  = 3'd0;
    localparam logic [2:0] c_s_recv  = 3'd1;
    localparam logic [2:0] c_s_check = 3'd2;
    localparam logic [2:0] c_s_wait  = 3'd3;
    localparam logic [2:0] c_s_send  = 3'd4;

    localparam logic [5:0] c_wait_last = 6'(NCR - 2);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [5:0]  r_bit_cnt;
    logic [5:0]  r_wait_cnt;
    logic [5:0]  r_tx_cnt;
    logic [47:0] r_rx_sr;
    logic [6:0]  r_rx_crc;
    logic [39:0] r_tx_sr;
    logic [6:0]  r_tx_crc;
    logic        r_cmd_out;
    logic        r_cmd_oe;
    logic        r_cmd_valid;
    logic        r_cmd_error;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;

    logic        w_frame_ok;
    logic        w_accept;
    logic [5:0]  w_rx_index;
    logic [6:0]  w_tx_crc_step;

    function automatic logic [6:0] f_crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign w_frame_ok    = ~r_rx_sr[47] & r_rx_sr[46] & r_rx_sr[0];
    assign w_rx_index    = r_rx_sr[45:40];
    assign w_tx_crc_step = f_crc7_step(r_tx_crc, r_tx_sr[39]);

`ifdef SD_RESP_CRC_CHECK_EN
    assign w_accept = w_frame_ok & (r_rx_crc == r_rx_sr[7:1]);
`else
    logic w_unused_crc;
    assign w_unused_crc = ^{r_rx_crc, r_rx_sr[7:1]};
    assign w_accept     = w_frame_ok;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= c_s_idle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_idle:  if (!cmd_in) w_state_next = c_s_recv;
            // A 0 transmission bit marks another card's response: ignore it.
            c_s_recv:  if (r_bit_cnt == 6'd0 && !cmd_in) w_state_next = c_s_idle;
                       else if (r_bit_cnt == 6'd46)      w_state_next = c_s_check;
            c_s_check: if (!w_accept || w_rx_index == NO_RESP) w_state_next = c_s_idle;
                       else                                   w_state_next = c_s_wait;
            c_s_wait:  if (r_wait_cnt == c_wait_last) w_state_next = c_s_send;
            c_s_send:  if (r_tx_cnt == 6'd47) w_state_next = c_s_idle;
            default:   w_state_next = c_s_idle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_tx_cnt    <= '0;
            r_rx_sr     <= '0;
            r_rx_crc    <= '0;
            r_tx_sr     <= '0;
            r_tx_crc    <= '0;
            r_cmd_out   <= 1'b1;
            r_cmd_oe    <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_error <= 1'b0;
            r_cmd_index <= '0;
            r_cmd_arg   <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_error <= 1'b0;
            case (r_state)
                c_s_idle: begin
                    r_bit_cnt <= '0;
                    r_rx_crc  <= '0;
                    if (!cmd_in) r_rx_sr <= {r_rx_sr[46:0], cmd_in};
                end
                c_s_recv: begin
                    r_rx_sr <= {r_rx_sr[46:0], cmd_in};
                    if (r_bit_cnt != 6'h3F) r_bit_cnt <= r_bit_cnt + 6'd1;
                    // The start bit leaves a zero CRC unchanged, so bits 1..39 suffice.
                    if (r_bit_cnt <= 6'd38) r_rx_crc <= f_crc7_step(r_rx_crc, cmd_in);
                end
                c_s_check: begin
                    r_wait_cnt <= '0;
                    if (w_accept) begin
                        r_cmd_index <= w_rx_index;
                        r_cmd_arg   <= r_rx_sr[39:8];
                        r_cmd_valid <= 1'b1;
                    end else begin
                        r_cmd_error <= 1'b1;
                    end
                end
                c_s_wait: begin
                    r_wait_cnt <= r_wait_cnt + 6'd1;
                    if (r_wait_cnt == c_wait_last) begin
                        r_tx_sr   <= {2'b00, r_cmd_index, card_status};
                        r_tx_crc  <= '0;
                        r_tx_cnt  <= '0;
                        r_cmd_oe  <= 1'b1;
                        r_cmd_out <= 1'b0;
                    end
                end
                c_s_send: begin
                    r_tx_cnt <= r_tx_cnt + 6'd1;
                    if (r_tx_cnt < 6'd39) begin
                        r_cmd_out <= r_tx_sr[38];
                        r_tx_sr   <= {r_tx_sr[38:0], 1'b0};
                        r_tx_crc  <= w_tx_crc_step;
                    end else if (r_tx_cnt == 6'd39) begin
                        // The 1 shifted in behind the CRC emerges as the end bit.
                        r_cmd_out <= w_tx_crc_step[6];
                        r_tx_crc  <= {w_tx_crc_step[5:0], 1'b1};
                    end else if (r_tx_cnt < 6'd47) begin
                        r_cmd_out <= r_tx_crc[6];
                        r_tx_crc  <= {r_tx_crc[5:0], 1'b0};
                    end else begin
                        r_cmd_out <= 1'b1;
                        r_cmd_oe  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_out   = r_cmd_out;
    assign cmd_oe    = r_cmd_oe;
    assign cmd_valid = r_cmd_valid;
    assign cmd_error = r_cmd_error;
    assign cmd_index = r_cmd_index;
    assign cmd_arg   = r_cmd_arg;
    assign busy      = (r_state != c_s_idle);

endmodule
`default_nettype wire

// File: tb/tb_sd_card_cmd_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sd_card_cmd_responder
// Purpose  : Directed self-checking bench for sd_card_cmd_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_card_cmd_responder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        cmd_in;
    logic [31:0] card_status;
    logic        cmd_out;
    logic        cmd_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_error;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [5:0]  m_index  = 6'd0;
    logic [31:0] m_arg    = 32'd0;

    always #5 CLK = ~CLK;

    sd_card_cmd_responder #(.NCR(2), .NO_RESP(6'd0)) u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .cmd_in      (cmd_in),
        .card_status (card_status),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .cmd_error   (cmd_error),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            tick();
        end
        cmd_in = 1'b1;
    endtask

    // Sends a frame and checks acceptance, the latched fields and the response.
    // abort_at >= 0 pulses RESET after that many response bits were seen.
    task automatic run_cmd(input string tag, input logic [47:0] f, input bit exp_ok,
                           input int abort_at);
        logic [47:0] rx;
        logic [47:0] exp_resp;
        logic [31:0] status0;
        bit          oe_bad;
        bit          resp;
        int          oe_seen;
        status0 = card_status;
        send_frame(f);
        tick();
        check({tag, "_valid"}, cmd_valid, exp_ok);
        check({tag, "_error"}, cmd_error, !exp_ok);
        if (exp_ok) begin
            m_index = f[45:40];
            m_arg   = f[39:8];
        end
        check({tag, "_index"}, cmd_index, m_index);
        check({tag, "_arg"}, cmd_arg, m_arg);
        check({tag, "_oe_early"}, cmd_oe, 1'b0);
        resp = exp_ok && (f[45:40] != 6'd0);
        if (resp) begin
            tick();
            check({tag, "_oe_rise"}, cmd_oe, 1'b1);
            oe_bad = 1'b0;
            rx     = '0;
            for (int i = 0; i < 48; i++) begin
                if (i > 0) tick();
                rx[47 - i] = cmd_out;
                if (!cmd_oe) oe_bad = 1'b1;
                if (i == 5) card_status = ~status0;
                if (i == abort_at) begin
                    RESET = 1'b1;
                    tick();
                    RESET = 1'b0;
                    check({tag, "_rst_oe"}, cmd_oe, 1'b0);
                    check({tag, "_rst_out"}, cmd_out, 1'b1);
                    check({tag, "_rst_busy"}, busy, 1'b0);
                    check({tag, "_rst_index"}, cmd_index, 6'd0);
                    m_index     = 6'd0;
                    m_arg       = 32'd0;
                    card_status = status0;
                    return;
                end
            end
            card_status = status0;
            check({tag, "_oe_held"}, oe_bad, 1'b0);
            exp_resp = {2'b00, f[45:40], status0,
                        crc7({2'b00, f[45:40], status0}), 1'b1};
            check({tag, "_resp"}, rx, exp_resp);
            tick();
            check({tag, "_oe_fall"}, cmd_oe, 1'b0);
            check({tag, "_out_idle"}, cmd_out, 1'b1);
            check({tag, "_busy_end"}, busy, 1'b0);
        end else begin
            oe_seen = 0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (cmd_oe) oe_seen++;
            end
            check({tag, "_no_resp"}, oe_seen, 0);
            check({tag, "_busy_end"}, busy, 1'b0);
        end
    endtask

    initial begin
        int pulses;
        RESET       = 1'b1;
        cmd_in      = 1'b1;
        card_status = 32'h0000_0900;
        repeat (3) tick();
        check("rst_out", cmd_out, 1'b1);
        check("rst_oe", cmd_oe, 1'b0);
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_error", cmd_error, 1'b0);
        check("rst_index", cmd_index, 6'd0);
        check("rst_arg", cmd_arg, 32'd0);
        check("rst_busy", busy, 1'b0);
        RESET = 1'b0;
        tick();

        run_cmd("cmd0", 48'h40_0000_0000_95, 1'b1, -1);
        run_cmd("cmd17", 48'h51_0000_0000_55, 1'b1, -1);
        card_status = 32'h0000_0120;
        run_cmd("cmd8", 48'h48_0000_01AA_87, 1'b1, -1);
        card_status = 32'h0000_0900;
`ifdef SD_RESP_CRC_CHECK_EN
        run_cmd("badcrc", 48'h51_0000_0000_57, 1'b0, -1);
`else
        run_cmd("badcrc", 48'h51_0000_0000_57, 1'b1, -1);
`endif
        run_cmd("badend", 48'h51_0000_0000_54, 1'b0, -1);

        // A frame whose transmission bit is 0 must be dropped silently.
        pulses = 0;
        cmd_in = 1'b0;
        tick();
        tick();
        cmd_in = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cmd_valid || cmd_error || cmd_oe) pulses++;
        end
        check("tbit0_silent", pulses, 0);
        check("tbit0_busy", busy, 1'b0);

        run_cmd("rst_send", 48'h51_0000_0000_55, 1'b1, 20);
        run_cmd("cmd8_after", 48'h48_0000_01AA_87, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
